// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a synchronous FIFO.
// Everything runs on clk. A per-bit clock-enable counter sets the baud rate.
// The frame format is captured when a word is popped, so cfg_* inputs may be
// changed at any time without corrupting the frame on the line.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [3:0]                    cfg_bits,
    input  logic [1:0]                    cfg_par,
    input  logic                          cfg_stop,
    input  logic                          tx_en,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] rd_word;
    logic              push;
    logic              pop;

    assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign rd_word  = mem[rd_ptr];

    // Storage array: written on every accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Launch-time preparation of the head word
    // ------------------------------------------------------------------
    logic [3:0]        eff_bits;
    logic [DATA_W-1:0] launch_word;
    logic              launch_par;

    // Resolve the bit count, mask unused data bits and precompute parity.
    always_comb begin
        eff_bits    = cfg_bits;
        launch_word = '0;
        if (cfg_bits == 4'd0 || cfg_bits > 4'(DATA_W)) begin
            eff_bits = 4'(DATA_W);
        end
        for (int unsigned i = 0; i < DATA_W; i++) begin
            launch_word[i] = rd_word[i] && (i < 32'(eff_bits));
        end
        launch_par = (cfg_par == 2'b01) ? ~^launch_word : ^launch_word;
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  baud_cnt;
    logic [DIV_W-1:0]  div_l;
    logic [3:0]        bits_l;
    logic [3:0]        bit_idx;
    logic [DATA_W:0]   data_sh;
    logic              par_en_l;
    logic              par_bit_l;
    logic              stop_l;
    logic              stop_idx;
    logic              bit_end;
    logic              last_data;
    logic              stop_end;
    logic              launch_ok;
    logic              txd_next;

    assign launch_ok = tx_en && (fifo_count != '0);
    assign bit_end   = (state != IDLE) && (baud_cnt == div_l);
    assign last_data = (bit_idx == bits_l - 4'd1);
    assign stop_end  = (state == STOP) && bit_end && (stop_idx == stop_l);
    // A launch pops from IDLE, or from the final stop cycle for back-to-back frames.
    assign pop       = launch_ok && ((state == IDLE) || stop_end);

    // State register and registered serial output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            txd   <= 1'b1;
        end else begin
            state <= state_next;
            txd   <= txd_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch_ok) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && last_data) begin
                    state_next = par_en_l ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (stop_end) begin
                    state_next = launch_ok ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: line level for the upcoming cycle, busy and end-of-frame strobe.
    always_comb begin
        tx_busy    = (state != IDLE);
        frame_done = stop_end;
        txd_next   = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            // data_sh shifts on the same edge a data bit ends, so the bit
            // about to go out is data_sh[1] then and data_sh[0] otherwise.
            DATA:    txd_next = (state == DATA && bit_end) ? data_sh[1] : data_sh[0];
            PARITY:  txd_next = par_bit_l;
            default: txd_next = 1'b1;
        endcase
    end

    // Baud counter: restarts at every bit boundary and idles at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if (state == IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
        end
    end

    // Frame datapath: capture word and format at launch, then step through bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_sh   <= '0;
            bits_l    <= '0;
            bit_idx   <= '0;
            par_en_l  <= 1'b0;
            par_bit_l <= 1'b0;
            stop_l    <= 1'b0;
            stop_idx  <= 1'b0;
            div_l     <= '0;
        end else if (pop) begin
            data_sh   <= {1'b0, launch_word};
            bits_l    <= eff_bits;
            bit_idx   <= '0;
            par_en_l  <= cfg_par[0] ^ cfg_par[1];
            par_bit_l <= launch_par;
            stop_l    <= cfg_stop;
            stop_idx  <= 1'b0;
            div_l     <= cfg_div;
        end else begin
            if (state == DATA && bit_end) begin
                bit_idx <= bit_idx + 4'd1;
                data_sh <= data_sh >> 1;
            end
            if (state == STOP && bit_end) begin
                stop_idx <= ~stop_idx;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a scoreboard of expected frames is filled as
// words are pushed and drained by a line monitor that decodes txd.
module tb_uart_tx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int DIV_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [DIV_W-1:0]        cfg_div;
    logic [3:0]              cfg_bits;
    logic [1:0]              cfg_par;
    logic                    cfg_stop;
    logic                    tx_en;
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    in_ready;
    logic                    txd;
    logic                    tx_busy;
    logic                    frame_done;
    logic [$clog2(DEPTH):0]  fifo_count;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_div    (cfg_div),
        .cfg_bits   (cfg_bits),
        .cfg_par    (cfg_par),
        .cfg_stop   (cfg_stop),
        .tx_en      (tx_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         bits;
        int         par;
        int         stop;
        int         div;
    } exp_t;

    exp_t        exp_q[$];
    int          gaps[$];
    int          n_checks    = 0;
    int          n_pass      = 0;
    int          cyc         = 0;
    int          last_end    = -100;
    int          frames_seen = 0;
    int          done_total  = 0;
    logic [31:0] last_obs    = '0;
    bit          mon_en      = 1'b0;
    bit          mon_busy    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected frame format from the configuration the bench has applied.
    function automatic exp_t mk(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.bits = (cfg_bits == 4'd0 || cfg_bits > 4'd8) ? 8 : int'(cfg_bits);
        e.par  = int'(cfg_par);
        e.stop = int'(cfg_stop);
        e.div  = int'(cfg_div);
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done) done_total <= done_total + 1;

    // Line monitor: decodes each frame and compares it against the scoreboard.
    initial begin : monitor
        exp_t        e;
        logic [31:0] ev;
        logic [31:0] ov;
        logic [7:0]  m;
        logic [7:0]  md;
        int          nb;
        int          unstable;
        int          dcnt;
        int          dlast;
        int          blow;
        forever begin
            @(negedge clk);
            if (mon_en && rst && txd == 1'b0) begin
                mon_busy = 1'b1;
                gaps.push_back(cyc - last_end - 1);
                check("exp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    m  = 8'((1 << e.bits) - 1);
                    md = e.data & m;
                    ev = '0;
                    nb = 1;
                    for (int i = 0; i < e.bits; i++) begin
                        ev[nb] = md[i];
                        nb++;
                    end
                    if (e.par == 1) begin
                        ev[nb] = ~^md;
                        nb++;
                    end else if (e.par == 2) begin
                        ev[nb] = ^md;
                        nb++;
                    end
                    for (int s = 0; s <= e.stop; s++) begin
                        ev[nb] = 1'b1;
                        nb++;
                    end
                    ov = '0; unstable = 0; dcnt = 0; dlast = 0; blow = 0;
                    for (int b = 0; b < nb; b++) begin
                        for (int c = 0; c <= e.div; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (c == 0) ov[b] = txd;
                            else if (txd !== ov[b]) unstable++;
                            if (frame_done) begin
                                dcnt++;
                                if (b == nb - 1 && c == e.div) dlast = 1;
                            end
                            if (!tx_busy) blow++;
                        end
                    end
                    last_end = cyc;
                    frames_seen++;
                    last_obs = ov;
                    check("frame_bits", ov, ev);
                    check("bit_stable", unstable, 0);
                    check("done_count", dcnt, 1);
                    check("done_last_cycle", dlast, 1);
                    check("busy_in_frame", blow, 0);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic push_word(input logic [7:0] d, input bit expect_frame);
        int n;
        if (expect_frame) exp_q.push_back(mk(d));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push_accepted", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy || tx_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", n < 5000, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int f0;
        int n;
        int d0;
        cfg_div = 16'd3; cfg_bits = 4'd8; cfg_par = 2'b00; cfg_stop = 1'b0;
        tx_en = 1'b1; in_valid = 1'b0; in_data = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Baseline frame and launch latency
        push_word(8'h0F, 1'b1);
        @(negedge clk);
        check("lat_count_e0", fifo_count, 1);
        check("lat_txd_e0", txd, 1);
        @(negedge clk);
        check("lat_txd_e1", txd, 0);
        check("lat_count_e1", fifo_count, 0);
        check("lat_busy_e1", tx_busy, 1);
        wait_idle();
        check("base_obs", last_obs, 32'h21E);
        check("base_idle_txd", txd, 1);

        // Parity modes with 7 data bits
        cfg_bits = 4'd7; cfg_par = 2'b10;
        push_word(8'h55, 1'b1);
        wait_idle();
        check("par_even_bit", last_obs[8], 0);
        cfg_par = 2'b01;
        push_word(8'h55, 1'b1);
        wait_idle();
        check("par_odd_bit", last_obs[8], 1);
        cfg_par = 2'b11;
        push_word(8'h55, 1'b1);
        wait_idle();
        check("par_none_stop", last_obs[8], 1);

        // Out-of-range bit counts fall back to 8
        cfg_par = 2'b00; cfg_bits = 4'd0;
        push_word(8'hA5, 1'b1);
        wait_idle();
        check("bits0_data", last_obs[8:1], 8'hA5);
        cfg_bits = 4'd12;
        push_word(8'hA5, 1'b1);
        wait_idle();
        check("bits12_data", last_obs[8:1], 8'hA5);
        check("bits12_stop", last_obs[9], 1);

        // FIFO full, then back-to-back drain
        cfg_bits = 4'd8;
        @(negedge clk);
        tx_en = 1'b0;
        push_word(8'h11, 1'b1);
        push_word(8'h22, 1'b1);
        push_word(8'h33, 1'b1);
        push_word(8'h44, 1'b1);
        fork
            push_word(8'h55, 1'b1);
        join_none
        repeat (3) @(negedge clk);
        check("full_ready", in_ready, 0);
        check("full_count", fifo_count, 4);
        check("full_idle_busy", tx_busy, 0);
        gaps.delete();
        tx_en = 1'b1;
        @(negedge clk);
        check("pop_ready", in_ready, 1);
        check("pop_count", fifo_count, 3);
        wait_idle();
        check("b2b_frames", gaps.size(), 5);
        for (int i = 1; i < gaps.size(); i++) begin
            check("b2b_gap", gaps[i], 0);
        end

        // Mid-frame config change and tx_en drop
        f0 = frames_seen;
        push_word(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        cfg_div = 16'd1; cfg_stop = 1'b1; tx_en = 1'b0;
        push_word(8'hC3, 1'b1);
        n = 0;
        while (frames_seen < f0 + 1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("mid_old_done", frames_seen, f0 + 1);
        check("mid_old_obs", last_obs, 32'h278);
        repeat (5) @(negedge clk);
        check("mid_hold_busy", tx_busy, 0);
        check("mid_hold_txd", txd, 1);
        check("mid_hold_count", fifo_count, 1);
        tx_en = 1'b1;
        wait_idle();
        check("mid_new_obs", last_obs, 32'h786);

        // Asynchronous reset in the middle of a data bit
        cfg_div = 16'd3; cfg_stop = 1'b0;
        mon_en = 1'b0;
        d0 = done_total;
        push_word(8'h00, 1'b0);
        push_word(8'h00, 1'b0);
        push_word(8'h00, 1'b0);
        repeat (6) @(negedge clk);
        check("abort_pre_txd", txd, 0);
        check("abort_pre_count", fifo_count, 2);
        #2;
        rst = 1'b0;
        #1;
        check("abort_async_txd", txd, 1);
        check("abort_async_busy", tx_busy, 0);
        check("abort_async_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_count", fifo_count, 0);
        check("abort_ready", in_ready, 1);
        check("abort_txd", txd, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_no_done", done_total, d0);
        check("done_vs_frames", done_total, frames_seen);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
